// File: rtl/mem_access.sv
// MEM stage data-memory access unit.
// Issues one bus transfer per load/store and formats load data.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;

  logic        is_lb, is_lbu, is_lh, is_lhu, is_lw;
  logic        is_sb, is_sh, is_sw;
  logic        is_load, is_store, is_acc;
  logic        is_byte, is_half, is_word;
  logic        mis;
  logic [3:0]  sel_n;
  logic [31:0] st_data;
  logic        ld_done;
  logic [31:0] ld_data;

  always_comb begin
    is_lb    = (aluop_i == EXE_LB_OP);
    is_lbu   = (aluop_i == EXE_LBU_OP);
    is_lh    = (aluop_i == EXE_LH_OP);
    is_lhu   = (aluop_i == EXE_LHU_OP);
    is_lw    = (aluop_i == EXE_LW_OP);
    is_sb    = (aluop_i == EXE_SB_OP);
    is_sh    = (aluop_i == EXE_SH_OP);
    is_sw    = (aluop_i == EXE_SW_OP);
    is_load  = is_lb | is_lbu | is_lh | is_lhu | is_lw;
    is_store = is_sb | is_sh | is_sw;
    is_acc   = is_load | is_store;
    is_byte  = is_lb | is_lbu | is_sb;
    is_half  = is_lh | is_lhu | is_sh;
    is_word  = is_lw | is_sw;
    mis      = (is_word & (mem_addr_i[1:0] != 2'b00))
             | (is_half & mem_addr_i[0]);
  end

  // Big-endian lane select and replicated store data.
  always_comb begin
    sel_n   = 4'b0000;
    st_data = 32'h0;
    unique case (1'b1)
      is_byte: begin
        sel_n   = 4'b1000 >> mem_addr_i[1:0];
        st_data = {4{reg2_i[7:0]}};
      end
      is_half: begin
        sel_n   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        st_data = {2{reg2_i[15:0]}};
      end
      is_word: begin
        sel_n   = 4'b1111;
        st_data = reg2_i;
      end
      default: begin
        sel_n   = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  // Format captured load data using the op/offset latched at issue.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    ld_done = 1'b0;
    ld_data = 32'h0;
    unique case (off_q)
      2'b00:   b = rdata_q[31:24];
      2'b01:   b = rdata_q[23:16];
      2'b10:   b = rdata_q[15:8];
      default: b = rdata_q[7:0];
    endcase
    h = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    unique case (op_q)
      EXE_LB_OP: begin
        ld_done = 1'b1;
        ld_data = {{24{b[7]}}, b};
      end
      EXE_LBU_OP: begin
        ld_done = 1'b1;
        ld_data = {24'h0, b};
      end
      EXE_LH_OP: begin
        ld_done = 1'b1;
        ld_data = {{16{h[15]}}, h};
      end
      EXE_LHU_OP: begin
        ld_done = 1'b1;
        ld_data = {16'h0, h};
      end
      EXE_LW_OP: begin
        ld_done = 1'b1;
        ld_data = rdata_q;
      end
      default: begin
        ld_done = 1'b0;
        ld_data = 32'h0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    op_d    = op_q;
    off_d   = off_q;
    unique case (state_q)
      IDLE: begin
        if (is_acc && !mis) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {mem_addr_i[31:2], 2'b00};
          sel_d   = sel_n;
          wdat_d  = is_store ? st_data : 32'h0;
          op_d    = aluop_i;
          off_d   = mem_addr_i[1:0];
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'h0;
          sel_d   = 4'b0000;
          wdat_d  = 32'h0;
          rdata_d = mem_rdata_i;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'b0000;
      wdat_q  <= 32'h0;
      rdata_q <= 32'h0;
      op_q    <= 8'h0;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      op_q    <= op_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'h0;
    whilo_o    = 1'b0;
    hi_o       = 32'h0;
    lo_o       = 32'h0;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    if (rst_n) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = wdata_i;
      whilo_o    = whilo_i;
      hi_o       = hi_i;
      lo_o       = lo_i;
      misalign_o = is_acc & mis;
      unique case (state_q)
        IDLE: begin
          if (is_acc) begin
            wreg_o     = 1'b0;
            stallreq_o = !mis;
          end
        end
        BUSY: begin
          wreg_o     = 1'b0;
          stallreq_o = 1'b1;
        end
        DONE: begin
          if (ld_done) begin
            wdata_o = ld_data;
          end else begin
            wreg_o  = 1'b0;
          end
        end
        default: begin
          wreg_o = 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_sel_o   = sel_q;
  assign mem_wdata_o = wdat_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access.
// Inputs change 1ns after posedge; outputs checked 2ns after posedge.
module tb_mem_access;

  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LW  = 8'b1110_0011;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] SB  = 8'b1110_1000;
  localparam logic [7:0] SH  = 8'b1110_1001;
  localparam logic [7:0] OR  = 8'b0010_0101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, hi_i, lo_i;
  logic [4:0]  wd_i;
  logic        wreg_i, whilo_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o, misalign_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_i(wd_i),
    .wreg_i(wreg_i), .wdata_i(wdata_i),
    .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic op(input logic [7:0] o, input logic [31:0] a);
    aluop_i    = o;
    mem_addr_i = a;
  endtask

  initial begin
    rst_n = 0; aluop_i = 8'h0; mem_addr_i = 0; reg2_i = 0;
    wd_i = 5'd9; wreg_i = 1; wdata_i = 32'h1111_2222;
    whilo_i = 1; hi_i = 32'hCAFE_0001; lo_i = 32'hBEEF_0002;
    mem_rdata_i = 0; mem_ack_i = 0;
    tick(); tick();
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_whilo", whilo_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_stall", stallreq_o, 0);

    // Pass-through op after reset
    rst_n = 1; op(OR, 32'h0);
    settle();
    chk("pt_wdata", wdata_o, 32'h1111_2222);
    chk("pt_wreg", wreg_o, 1);
    chk("pt_wd", wd_o, 9);
    chk("pt_hi", hi_o, 32'hCAFE_0001);
    chk("pt_lo", lo_o, 32'hBEEF_0002);
    chk("pt_stall", stallreq_o, 0);

    // LB 0x101
    tick();
    op(LB, 32'h0000_0101); wd_i = 3; wdata_i = 32'hDEAD;
    settle();
    chk("lb_idle_stall", stallreq_o, 1);
    chk("lb_idle_wreg", wreg_o, 0);
    chk("lb_idle_req", mem_req_o, 0);
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'h1180_3344;
    settle();
    chk("lb_busy_req", mem_req_o, 1);
    chk("lb_busy_we", mem_we_o, 0);
    chk("lb_busy_addr", mem_addr_o, 32'h100);
    chk("lb_busy_sel", mem_sel_o, 4'b0100);
    chk("lb_busy_stall", stallreq_o, 1);
    chk("lb_busy_wreg", wreg_o, 0);
    tick();
    mem_ack_i = 0;
    settle();
    chk("lb_done_stall", stallreq_o, 0);
    chk("lb_done_wreg", wreg_o, 1);
    chk("lb_done_wdata", wdata_o, 32'hFFFF_FF80);
    chk("lb_done_wd", wd_o, 3);
    chk("lb_done_req", mem_req_o, 0);

    // LHU 0x202 issued right after DONE
    tick();
    op(LHU, 32'h0000_0202); wd_i = 7;
    settle();
    chk("lhu_idle_stall", stallreq_o, 1);
    chk("lhu_idle_wreg", wreg_o, 0);
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'hAAAA_8001;
    settle();
    chk("lhu_busy_sel", mem_sel_o, 4'b0011);
    chk("lhu_busy_addr", mem_addr_o, 32'h200);
    chk("lhu_busy_wreg", wreg_o, 0);
    tick();
    mem_ack_i = 0;
    settle();
    chk("lhu_done_wdata", wdata_o, 32'h0000_8001);
    chk("lhu_done_wreg", wreg_o, 1);

    // SH 0x12, ack on third BUSY cycle
    tick();
    op(SH, 32'h0000_0012); reg2_i = 32'h1234_ABCD;
    settle();
    chk("sh_idle_stall", stallreq_o, 1);
    chk("sh_idle_wreg", wreg_o, 0);
    tick();
    settle();
    chk("sh_b1_req", mem_req_o, 1);
    chk("sh_b1_we", mem_we_o, 1);
    chk("sh_b1_addr", mem_addr_o, 32'h10);
    chk("sh_b1_sel", mem_sel_o, 4'b0011);
    chk("sh_b1_wdata", mem_wdata_o, 32'hABCD_ABCD);
    chk("sh_b1_stall", stallreq_o, 1);
    tick();
    settle();
    chk("sh_b2_req", mem_req_o, 1);
    chk("sh_b2_wdata", mem_wdata_o, 32'hABCD_ABCD);
    chk("sh_b2_stall", stallreq_o, 1);
    chk("sh_b2_wreg", wreg_o, 0);
    tick();
    mem_ack_i = 1;
    settle();
    chk("sh_b3_stall", stallreq_o, 1);
    chk("sh_b3_sel", mem_sel_o, 4'b0011);
    tick();
    mem_ack_i = 0;
    settle();
    chk("sh_done_stall", stallreq_o, 0);
    chk("sh_done_wreg", wreg_o, 0);
    chk("sh_done_req", mem_req_o, 0);
    chk("sh_done_we", mem_we_o, 0);
    chk("sh_done_wdata", mem_wdata_o, 0);

    // Ack while IDLE is ignored
    tick();
    op(OR, 32'h0); wdata_i = 32'h1357_2468;
    mem_ack_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
    settle();
    chk("ackidle_wdata", wdata_o, 32'h1357_2468);
    tick();
    mem_ack_i = 0;
    settle();
    chk("ackidle_req", mem_req_o, 0);
    chk("ackidle_stall", stallreq_o, 0);
    chk("ackidle_wreg", wreg_o, 1);

    // Misaligned LW 0x103
    op(LW, 32'h0000_0103);
    settle();
    chk("mis_flag", misalign_o, 1);
    chk("mis_stall", stallreq_o, 0);
    chk("mis_wreg", wreg_o, 0);
    tick();
    chk("mis_req", mem_req_o, 0);
    chk("mis_flag2", misalign_o, 1);

    // SB 0x3 (lowest lane)
    op(SB, 32'h0000_0003); reg2_i = 32'h0000_00EF;
    settle();
    chk("sb_misalign", misalign_o, 0);
    chk("sb_idle_stall", stallreq_o, 1);
    tick();
    mem_ack_i = 1;
    settle();
    chk("sb_sel", mem_sel_o, 4'b0001);
    chk("sb_wdata", mem_wdata_o, 32'hEFEF_EFEF);
    chk("sb_addr", mem_addr_o, 32'h0);
    tick();
    mem_ack_i = 0;
    settle();
    chk("sb_done_wreg", wreg_o, 0);

    // LH 0x0, sign extension of upper half
    tick();
    op(LH, 32'h0000_0000);
    settle();
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'h8123_4567;
    settle();
    chk("lh_sel", mem_sel_o, 4'b1100);
    tick();
    mem_ack_i = 0;
    settle();
    chk("lh_wdata", wdata_o, 32'hFFFF_8123);

    // LW issued, reset during BUSY, late ack
    tick();
    op(LW, 32'h0000_0100);
    settle();
    tick();
    settle();
    chk("rb_busy_req", mem_req_o, 1);
    rst_n = 0;
    settle();
    chk("rb_rst_stall", stallreq_o, 0);
    chk("rb_rst_wreg", wreg_o, 0);
    chk("rb_rst_wdata", wdata_o, 0);
    tick();
    chk("rb_req_clr", mem_req_o, 0);
    rst_n = 1; op(OR, 32'h0); wdata_i = 32'h5A5A_0000;
    settle();
    chk("rb_or_wdata", wdata_o, 32'h5A5A_0000);
    chk("rb_or_stall", stallreq_o, 0);
    chk("rb_or_wreg", wreg_o, 1);
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'h7777_7777;
    settle();
    chk("rb_ack_stall", stallreq_o, 0);
    tick();
    mem_ack_i = 0;
    settle();
    chk("rb_late_req", mem_req_o, 0);
    chk("rb_late_wdata", wdata_o, 32'h5A5A_0000);
    chk("rb_late_stall", stallreq_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 aluop_i  in  8  op code from EX/MEM register; load/store codes are EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP from macro.v.
REQ-004 mem_addr_i  in  32  effective byte address computed by EX.
REQ-005 reg2_i  in  32  store source data.
REQ-006 wd_i  in  5  destination register address.
REQ-007 wreg_i  in  1  destination write enable.
REQ-008 wdata_i  in  32  EX result.
REQ-009 whilo_i / hi_i / lo_i  in  1/32/32  HI/LO write request, passed through.
REQ-010 wd_o  out  5  destination register address to MEM/WB.
REQ-011 wreg_o  out  1  destination write enable to MEM/WB.
REQ-012 wdata_o  out  32  write-back data.
REQ-013 whilo_o / hi_o / lo_o  out  1/32/32  equal to whilo_i / hi_i / lo_i.
REQ-014 stallreq_o  out  1  pipeline stall request while an access is outstanding.
REQ-015 misalign_o  out  1  misaligned access flag, combinational.
REQ-016 mem_req_o  out  1  data-bus request, registered.
REQ-017 mem_we_o  out  1  1 = store, 0 = load, registered.
REQ-018 mem_addr_o  out  32  word address {mem_addr_i[31:2],2'b00}, registered.
REQ-019 mem_sel_o  out  4  byte-lane enables, registered.
REQ-020 mem_wdata_o  out  32  store data, registered.
REQ-021 mem_rdata_i  in  32  read data, valid when mem_ack_i=1.
REQ-022 mem_ack_i  in  1  one-cycle transfer completion.

Function
REQ-023 Access op: any of the 8 load/store codes.
- All other ops pass through combinationally: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i.
- They cause stallreq_o=0 and no bus activity.
REQ-024 wd_o=wd_i at all times outside reset.
REQ-025 Alignment rules:
- LW/SW need addr[1:0]=00; LH/LHU/SH need addr[0]=0.
- Misaligned: misalign_o=1, no request, wreg_o=0, stallreq_o=0, state stays IDLE.
REQ-026 FSM has three states: IDLE, BUSY, DONE.
REQ-027 IDLE with an aligned access op:
- stallreq_o=1 in that cycle.
- Next edge: state -> BUSY; mem_req_o=1 and mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o loaded.
REQ-028 BUSY:
- Bus outputs held stable; stallreq_o=1.
- Edge with mem_ack_i=1: bus registers cleared to 0, mem_rdata_i captured into the load register, state -> DONE.
- No ack: remain in BUSY indefinitely.
REQ-029 DONE:
- stallreq_o=0.
- Load: wreg_o=wreg_i, wdata_o=formatted captured data.
- Store: wreg_o=0.
- Next edge: state -> IDLE unconditionally.
REQ-030 For an access op in IDLE or BUSY, wreg_o=0 (no stale forwarding).
REQ-031 Latency with ack in the first BUSY cycle: stallreq_o high 2 cycles; result presented in the 3rd cycle (DONE).
REQ-032 Byte lanes are big-endian:
- Byte, addr[1:0]=00/01/10/11: sel 1000/0100/0010/0001, lane rdata[31:24]/[23:16]/[15:8]/[7:0].
- Half, addr[1]=0: sel 1100, lane [31:16]; addr[1]=1: sel 0011, lane [15:0].
- Word: sel 1111.
REQ-033 Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW full word.
REQ-034 Store data: SB {4{reg2_i[7:0]}}; SH {2{reg2_i[15:0]}}; SW reg2_i.
REQ-035 mem_ack_i outside BUSY is ignored: no capture, no state change.
REQ-036 Bus outputs are 0 whenever state is not BUSY.
REQ-037 An access op arriving in the cycle after DONE starts a new issue with no extra gap.

Reset
REQ-038 rst_n=0 at a clock edge sets:
- state IDLE.
- all bus registers and the load register to 0.
REQ-039 While rst_n=0, all combinational outputs are 0: wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o, misalign_o.
REQ-040 Reset during BUSY abandons the transfer:
- mem_req_o=0 from the next cycle.
- A late mem_ack_i is ignored.

Verification
REQ-041 LB, addr 0x00000101, ack in first BUSY cycle, rdata 0x11803344 -> mem_addr_o 0x100, sel 0100, stallreq_o high 2 cycles, DONE wdata_o 0xFFFFFF80.
REQ-042 LHU, addr 0x202, rdata 0xAAAA8001 -> sel 0011, wdata_o 0x00008001, wreg_o=1 only in DONE.
REQ-043 SH, addr 0x12, reg2 0x1234ABCD, ack on 3rd BUSY cycle -> mem_we_o=1, mem_addr_o 0x10, sel 0011, mem_wdata_o 0xABCDABCD, stallreq_o high 4 cycles, wreg_o=0 throughout.
REQ-044 LW, addr 0x103 -> misalign_o=1, mem_req_o never high, stallreq_o=0, wreg_o=0.
REQ-045 LW issued, rst_n=0 during BUSY, ack 2 cycles later -> mem_req_o=0 after reset edge, state IDLE, ack ignored; following OR op with wdata_i 0x5A5A0000 -> wdata_o 0x5A5A0000, no stall.
